// File: rtl/decode_pkg.sv
// Shared encodings, class indices and the pipeline stage record for the
// MIPS ID-stage decoder.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam int CLS_W     = 16;
  localparam int CLS_ADDU  = 0;
  localparam int CLS_SUBU  = 1;
  localparam int CLS_ORI   = 2;
  localparam int CLS_LW    = 3;
  localparam int CLS_SW    = 4;
  localparam int CLS_BEQ   = 5;
  localparam int CLS_LUI   = 6;
  localparam int CLS_JAL   = 7;
  localparam int CLS_J     = 8;
  localparam int CLS_JR    = 9;
  localparam int CLS_ADDIU = 10;
  localparam int CLS_SLT   = 11;
  localparam int CLS_BNE   = 12;
  localparam int CLS_JALR  = 13;
  localparam int CLS_LB    = 14;
  localparam int CLS_SB    = 15;

  // Classes that only exist when the extended set is enabled.
  localparam logic [CLS_W-1:0] EXT_MASK = 16'hFC00;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [CLS_W-1:0] cls;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       wa;
    logic [1:0]       tnew;
    logic [1:0]       tuse_rs;
    logic [1:0]       tuse_rt;
    logic             illegal;
  } stage_t;

  function automatic stage_t bubble_rec();
    stage_t b;
    b         = '0;
    b.tuse_rs = TUSE_NONE;
    b.tuse_rt = TUSE_NONE;
    return b;
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction-word decode: one-hot class, register fields,
// write register and hazard timing (Tnew at stage 1, Tuse).
module instr_class_decode
  import decode_pkg::*;
#(
  parameter int EXT_SET = 0
) (
  input  logic [31:0]      instr,
  output logic [CLS_W-1:0] cls,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       wa,
  output logic [1:0]       tnew,
  output logic [1:0]       tuse_rs,
  output logic [1:0]       tuse_rt,
  output logic             illegal
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             is_r;
  logic [CLS_W-1:0] raw;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign is_r   = (opcode == OP_RTYPE);
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];

  always_comb begin
    raw            = '0;
    raw[CLS_ADDU]  = is_r && (funct == FN_ADDU);
    raw[CLS_SUBU]  = is_r && (funct == FN_SUBU);
    raw[CLS_JR]    = is_r && (funct == FN_JR);
    raw[CLS_SLT]   = is_r && (funct == FN_SLT);
    raw[CLS_JALR]  = is_r && (funct == FN_JALR);
    raw[CLS_ORI]   = (opcode == OP_ORI);
    raw[CLS_LW]    = (opcode == OP_LW);
    raw[CLS_SW]    = (opcode == OP_SW);
    raw[CLS_BEQ]   = (opcode == OP_BEQ);
    raw[CLS_LUI]   = (opcode == OP_LUI);
    raw[CLS_JAL]   = (opcode == OP_JAL);
    raw[CLS_J]     = (opcode == OP_J);
    raw[CLS_ADDIU] = (opcode == OP_ADDIU);
    raw[CLS_BNE]   = (opcode == OP_BNE);
    raw[CLS_LB]    = (opcode == OP_LB);
    raw[CLS_SB]    = (opcode == OP_SB);
  end

  // Disabled extended encodings fall through to the illegal path.
  assign cls     = (EXT_SET != 0) ? raw : (raw & ~EXT_MASK);
  assign illegal = (instr != 32'd0) && (cls == '0);

  always_comb begin
    wa = 5'd0;
    if (cls[CLS_ADDU] || cls[CLS_SUBU] || cls[CLS_SLT] || cls[CLS_JALR])
      wa = instr[15:11];
    else if (cls[CLS_ORI] || cls[CLS_LW] || cls[CLS_LUI] || cls[CLS_ADDIU] || cls[CLS_LB])
      wa = instr[20:16];
    else if (cls[CLS_JAL])
      wa = 5'd31;
  end

  always_comb begin
    tnew = 2'd0;
    if (cls[CLS_LW] || cls[CLS_LB])
      tnew = 2'd2;
    else if (cls[CLS_ADDU] || cls[CLS_SUBU] || cls[CLS_ORI] || cls[CLS_LUI] ||
             cls[CLS_ADDIU] || cls[CLS_SLT])
      tnew = 2'd1;
  end

  // lui carries no rs operand, so it is left out of the rs consumers.
  always_comb begin
    tuse_rs = TUSE_NONE;
    if (cls[CLS_BEQ] || cls[CLS_BNE] || cls[CLS_JR] || cls[CLS_JALR])
      tuse_rs = 2'd0;
    else if (cls[CLS_ADDU] || cls[CLS_SUBU] || cls[CLS_SLT] || cls[CLS_ORI] ||
             cls[CLS_ADDIU] || cls[CLS_LW] || cls[CLS_LB] || cls[CLS_SW] || cls[CLS_SB])
      tuse_rs = 2'd1;
  end

  always_comb begin
    tuse_rt = TUSE_NONE;
    if (cls[CLS_BEQ] || cls[CLS_BNE])
      tuse_rt = 2'd0;
    else if (cls[CLS_ADDU] || cls[CLS_SUBU] || cls[CLS_SLT])
      tuse_rt = 2'd1;
    else if (cls[CLS_SW] || cls[CLS_SB])
      tuse_rt = 2'd2;
  end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined ID-stage decoder: combinational decode followed by STAGES
// register stages with stall/flush, Tnew ageing and a retired counter.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int STAGES  = 1,
  parameter int EXT_SET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] out_cls,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_wa,
  output logic [1:0]  out_tnew,
  output logic [1:0]  out_tuse_rs,
  output logic [1:0]  out_tuse_rt,
  output logic        out_illegal,
  output logic [15:0] decode_cnt
);

  stage_t     dec_rec;
  stage_t     stage_reg [STAGES];
  logic [15:0] cnt_reg;

  logic [CLS_W-1:0] d_cls;
  logic [4:0]       d_rs, d_rt, d_wa;
  logic [1:0]       d_tnew, d_tuse_rs, d_tuse_rt;
  logic             d_illegal;

  instr_class_decode #(.EXT_SET(EXT_SET)) u_dec (
    .instr   (instr),
    .cls     (d_cls),
    .rs      (d_rs),
    .rt      (d_rt),
    .wa      (d_wa),
    .tnew    (d_tnew),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .illegal (d_illegal)
  );

  always_comb begin
    dec_rec         = bubble_rec();
    dec_rec.valid   = 1'b1;
    dec_rec.cls     = d_cls;
    dec_rec.rs      = d_rs;
    dec_rec.rt      = d_rt;
    dec_rec.wa      = d_wa;
    dec_rec.tnew    = d_tnew;
    dec_rec.tuse_rs = d_tuse_rs;
    dec_rec.tuse_rt = d_tuse_rt;
    dec_rec.illegal = d_illegal;
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset)
            stage_reg[0] <= bubble_rec();
          else if (flush)
            stage_reg[0] <= bubble_rec();
          else if (!stall)
            stage_reg[0] <= in_valid ? dec_rec : bubble_rec();
        end
      end else begin : g_next
        stage_t aged;
        always_comb begin
          aged      = stage_reg[gi-1];
          aged.tnew = tnew_dec(stage_reg[gi-1].tnew);
        end
        always_ff @(posedge clk or posedge reset) begin
          if (reset)
            stage_reg[gi] <= bubble_rec();
          else if (flush)
            stage_reg[gi] <= bubble_rec();
          else if (!stall)
            stage_reg[gi] <= aged;
        end
      end
    end
  endgenerate

  // Retirement is counted as the last stage hands its instruction onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_reg <= 16'd0;
    else if (stage_reg[STAGES-1].valid && !stall && !flush)
      cnt_reg <= cnt_reg + 16'd1;
  end

  assign out_valid   = stage_reg[STAGES-1].valid;
  assign out_cls     = stage_reg[STAGES-1].cls;
  assign out_rs      = stage_reg[STAGES-1].rs;
  assign out_rt      = stage_reg[STAGES-1].rt;
  assign out_wa      = stage_reg[STAGES-1].wa;
  assign out_tnew    = stage_reg[STAGES-1].tnew;
  assign out_tuse_rs = stage_reg[STAGES-1].tuse_rs;
  assign out_tuse_rt = stage_reg[STAGES-1].tuse_rt;
  assign out_illegal = stage_reg[STAGES-1].illegal;
  assign decode_cnt  = cnt_reg;

endmodule
